// File: rtl/result_unloader_module_if.sv
// Bus bundle for result_unloader_module: the score stream from the network
// and the AXI4-Lite register port toward the processor.
interface result_unloader_module_if #(
    parameter int DATA_WIDTH = 32
);
    // Score stream
    logic [DATA_WIDTH-1:0] y_tdata;
    logic                  y_tvalid;
    logic                  y_tready;

    // AXI4-Lite write address / data / response
    logic [31:0] S_AXI_awaddr;
    logic [2:0]  S_AXI_awprot;
    logic        S_AXI_awvalid;
    logic        S_AXI_awready;
    logic [31:0] S_AXI_wdata;
    logic [3:0]  S_AXI_wstrb;
    logic        S_AXI_wvalid;
    logic        S_AXI_wready;
    logic [1:0]  S_AXI_bresp;
    logic        S_AXI_bvalid;
    logic        S_AXI_bready;

    // AXI4-Lite read address / data
    logic [31:0] S_AXI_araddr;
    logic [2:0]  S_AXI_arprot;
    logic        S_AXI_arvalid;
    logic        S_AXI_arready;
    logic [31:0] S_AXI_rdata;
    logic [1:0]  S_AXI_rresp;
    logic        S_AXI_rvalid;
    logic        S_AXI_rready;

    modport slave (
        input  y_tdata, y_tvalid,
        output y_tready,
        input  S_AXI_awaddr, S_AXI_awprot, S_AXI_awvalid,
        output S_AXI_awready,
        input  S_AXI_wdata, S_AXI_wstrb, S_AXI_wvalid,
        output S_AXI_wready,
        output S_AXI_bresp, S_AXI_bvalid,
        input  S_AXI_bready,
        input  S_AXI_araddr, S_AXI_arprot, S_AXI_arvalid,
        output S_AXI_arready,
        output S_AXI_rdata, S_AXI_rresp, S_AXI_rvalid,
        input  S_AXI_rready
    );

    modport master (
        output y_tdata, y_tvalid,
        input  y_tready,
        output S_AXI_awaddr, S_AXI_awprot, S_AXI_awvalid,
        input  S_AXI_awready,
        output S_AXI_wdata, S_AXI_wstrb, S_AXI_wvalid,
        input  S_AXI_wready,
        input  S_AXI_bresp, S_AXI_bvalid,
        output S_AXI_bready,
        output S_AXI_araddr, S_AXI_arprot, S_AXI_arvalid,
        input  S_AXI_arready,
        input  S_AXI_rdata, S_AXI_rresp, S_AXI_rvalid,
        output S_AXI_rready
    );
endinterface

// File: rtl/result_unloader_module.sv
// Captures DEPTH signed class scores from a stream, tracks the running
// argmax, and exposes scores / status / argmax over an AXI4-Lite register map.
module result_unloader_module #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 10
) (
    input  logic s_axi_aclk,
    input  logic s_axi_areset,
    input  logic start,
    output logic done,
    result_unloader_module_if.slave bus
);

    localparam int CNT_W = 5;
    localparam int IDX_W = 4;
    localparam logic [5:0] STATUS_WORD = 6'h10;
    localparam logic [5:0] ARGMAX_WORD = 6'h11;

    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

    state_t state;
    state_t state_next;
    logic   capture_start;

    logic                         start_prev;
    logic                         start_rise;
    logic                         beat;
    logic                         last_beat;
    logic [CNT_W-1:0]             count;
    logic signed [DATA_WIDTH-1:0] scores [DEPTH];
    logic signed [DATA_WIDTH-1:0] max_val;
    logic [IDX_W-1:0]             max_idx;

    logic        aw_ready;
    logic        aw_hs;
    logic        w1c;
    logic        b_valid;
    logic        ar_ready;
    logic        r_valid;
    logic [31:0] r_data;
    logic [31:0] rd_word;
    logic [5:0]  rd_idx;
    logic        unused_inputs;

    // Scores narrower than the bus are sign-extended so software sees the true value.
    function automatic logic [31:0] to_word(input logic signed [DATA_WIDTH-1:0] v);
        return 32'(v);
    endfunction

    assign start_rise = start & ~start_prev;
    assign beat       = bus.y_tvalid & bus.y_tready;
    assign last_beat  = beat && (count == CNT_W'(DEPTH - 1));

    assign aw_hs = aw_ready & bus.S_AXI_awvalid & bus.S_AXI_wvalid;
    assign w1c   = aw_hs && (bus.S_AXI_awaddr[7:2] == STATUS_WORD) && bus.S_AXI_wdata[0];

    assign bus.y_tready      = (state == CAPTURE);
    assign bus.S_AXI_awready = aw_ready;
    assign bus.S_AXI_wready  = aw_ready;
    assign bus.S_AXI_bvalid  = b_valid;
    assign bus.S_AXI_bresp   = 2'b00;
    assign bus.S_AXI_arready = ar_ready;
    assign bus.S_AXI_rvalid  = r_valid;
    assign bus.S_AXI_rdata   = r_data;
    assign bus.S_AXI_rresp   = 2'b00;

    // Protection, strobes and the untranslated address bits carry no meaning here.
    assign unused_inputs = ^{bus.S_AXI_awprot, bus.S_AXI_arprot, bus.S_AXI_wstrb,
                             bus.S_AXI_awaddr[31:8], bus.S_AXI_awaddr[1:0],
                             bus.S_AXI_araddr[31:8], bus.S_AXI_araddr[1:0],
                             bus.S_AXI_wdata[31:1]};

    // Remember start so a held level arms only one capture.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) start_prev <= 1'b0;
        else              start_prev <= start;
    end

    // Capture FSM state register.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) state <= IDLE;
        else              state <= state_next;
    end

    // Next state: start edges are ignored while capturing; a new start beats a W1C.
    always_comb begin
        state_next    = state;
        capture_start = 1'b0;
        case (state)
            IDLE: begin
                if (start_rise) begin
                    state_next    = CAPTURE;
                    capture_start = 1'b1;
                end
            end
            CAPTURE: begin
                if (last_beat) state_next = DONE;
            end
            DONE: begin
                if (start_rise) begin
                    state_next    = CAPTURE;
                    capture_start = 1'b1;
                end else if (w1c) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Sticky done flag; the final beat takes priority over a same-cycle W1C.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset)       done <= 1'b0;
        else if (capture_start) done <= 1'b0;
        else if (last_beat)     done <= 1'b1;
        else if (w1c)           done <= 1'b0;
    end

    // Beat counter doubles as the write pointer into the score buffer.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset)       count <= '0;
        else if (capture_start) count <= '0;
        else if (beat)          count <= count + 1'b1;
    end

    // Score buffer; deliberately left intact when a new capture starts.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            for (int i = 0; i < DEPTH; i++) scores[i] <= '0;
        end else if (beat) begin
            scores[count[IDX_W-1:0]] <= bus.y_tdata;
        end
    end

    // Running argmax; strict greater-than keeps the lowest index on ties.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            max_val <= '0;
            max_idx <= '0;
        end else if (capture_start) begin
            max_val <= '0;
            max_idx <= '0;
        end else if (beat) begin
            if ((count == '0) || ($signed(bus.y_tdata) > max_val)) begin
                max_val <= bus.y_tdata;
                max_idx <= count[IDX_W-1:0];
            end
        end
    end

    // Write channel: one-cycle AW/W accept pulse, then hold B until taken.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            aw_ready <= 1'b0;
            b_valid  <= 1'b0;
        end else begin
            aw_ready <= ~aw_ready & bus.S_AXI_awvalid & bus.S_AXI_wvalid & ~b_valid;
            if (aw_hs)                  b_valid <= 1'b1;
            else if (bus.S_AXI_bready) b_valid <= 1'b0;
        end
    end

    // Read decode on the word index; unmapped words read as zero.
    always_comb begin
        rd_word = '0;
        rd_idx  = bus.S_AXI_araddr[7:2];
        if (int'(rd_idx) < DEPTH)       rd_word = to_word(scores[rd_idx[IDX_W-1:0]]);
        else if (rd_idx == STATUS_WORD) rd_word = 32'({count, 6'b0, (state == CAPTURE), done});
        else if (rd_idx == ARGMAX_WORD) rd_word = 32'(max_idx);
    end

    // Read channel: single outstanding read, data frozen until R handshake.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            ar_ready <= 1'b0;
            r_valid  <= 1'b0;
            r_data   <= '0;
        end else if (ar_ready && bus.S_AXI_arvalid) begin
            ar_ready <= 1'b0;
            r_valid  <= 1'b1;
            r_data   <= rd_word;
        end else if (r_valid && bus.S_AXI_rready) begin
            r_valid  <= 1'b0;
            ar_ready <= 1'b1;
        end else if (!r_valid) begin
            ar_ready <= 1'b1;
        end
    end

endmodule

// File: tb/tb_result_unloader_module.sv
// Randomized self-checking bench for result_unloader_module with a
// transaction-level reference model of the score buffer, status and argmax.
module tb_result_unloader_module;

    localparam int DEPTH = 10;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic done;

    result_unloader_module_if #(.DATA_WIDTH(32)) bus ();

    result_unloader_module #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .s_axi_aclk  (clk),
        .s_axi_areset(rst),
        .start       (start),
        .done        (done),
        .bus         (bus.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] m_scores [16];
    int          m_count;
    bit          m_busy;
    bit          m_done;
    bit          m_start_prev;

    logic [31:0] stim [16];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_scores[i] = '0;
        m_count      = 0;
        m_busy       = 1'b0;
        m_done       = 1'b0;
        m_start_prev = 1'b0;
    endtask

    // Lowest index holding the largest signed score of the current capture.
    function automatic int model_argmax();
        int best = 0;
        for (int i = 1; i < m_count; i++)
            if ($signed(m_scores[i]) > $signed(m_scores[best])) best = i;
        return best;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        int w = int'(addr[7:2]);
        if (w < DEPTH) return m_scores[w];
        if (w == 16)   return (32'(m_count) << 8) | (32'(m_busy) << 1) | 32'(m_done);
        if (w == 17)   return 32'(model_argmax());
        return 32'h0;
    endfunction

    // Apply what the coming clock edge does to the model, then advance.
    task automatic tick();
        bit rise;
        if (rst) begin
            model_reset();
        end else begin
            rise = start && !m_start_prev;
            m_start_prev = start;
            if (m_busy) begin
                if (bus.y_tvalid) begin
                    m_scores[m_count] = bus.y_tdata;
                    m_count++;
                    if (m_count == DEPTH) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                    end
                end
            end else if (rise) begin
                m_busy  = 1'b1;
                m_count = 0;
                m_done  = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_stream(input string tag);
        check_eq({tag, "_tready"}, 32'(bus.y_tready), 32'(m_busy));
        check_eq({tag, "_done"}, 32'(done), 32'(m_done));
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_outs"},
                 {19'b0, bus.y_tready, done, bus.S_AXI_awready, bus.S_AXI_wready,
                  bus.S_AXI_bresp, bus.S_AXI_bvalid, bus.S_AXI_arready,
                  bus.S_AXI_rresp, bus.S_AXI_rvalid}, 32'h0);
        check_eq({tag, "_rdata"}, bus.S_AXI_rdata, 32'h0);
    endtask

    task automatic axi_read(input string tag, input logic [31:0] addr, input int rdelay,
                            output logic [31:0] data);
        logic [31:0] exp = '0;
        bit ok = 1'b0;
        bus.S_AXI_araddr  = addr;
        bus.S_AXI_arvalid = 1'b1;
        bus.S_AXI_rready  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.S_AXI_arready) begin
                exp = model_read(addr);
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        bus.S_AXI_arvalid = 1'b0;
        check_eq({tag, "_ar_hs"}, 32'(ok), 32'h1);
        check_eq({tag, "_rvalid"}, 32'(bus.S_AXI_rvalid), 32'h1);
        data = bus.S_AXI_rdata;
        check_eq(tag, data, exp);
        for (int i = 0; i < rdelay; i++) begin
            tick();
            check_eq({tag, "_rvalid_hold"}, 32'(bus.S_AXI_rvalid), 32'h1);
            check_eq({tag, "_rdata_hold"}, bus.S_AXI_rdata, data);
        end
        bus.S_AXI_rready = 1'b1;
        tick();
        bus.S_AXI_rready = 1'b0;
        check_eq({tag, "_rvalid_clr"}, 32'(bus.S_AXI_rvalid), 32'h0);
    endtask

    task automatic axi_write(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                             input int bdelay);
        bit ok = 1'b0;
        bit clr = 1'b0;
        bus.S_AXI_awaddr  = addr;
        bus.S_AXI_wdata   = wdata;
        bus.S_AXI_wstrb   = 4'hF;
        bus.S_AXI_awvalid = 1'b1;
        bus.S_AXI_wvalid  = 1'b1;
        bus.S_AXI_bready  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.S_AXI_awready) begin
                check_eq({tag, "_wready"}, 32'(bus.S_AXI_wready), 32'h1);
                clr = (addr[7:2] == 6'h10) && wdata[0];
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (clr) m_done = 1'b0;
        bus.S_AXI_awvalid = 1'b0;
        bus.S_AXI_wvalid  = 1'b0;
        check_eq({tag, "_aw_hs"}, 32'(ok), 32'h1);
        check_eq({tag, "_bvalid"}, 32'(bus.S_AXI_bvalid), 32'h1);
        check_eq({tag, "_bresp"}, 32'(bus.S_AXI_bresp), 32'h0);
        for (int i = 0; i < bdelay; i++) begin
            tick();
            check_eq({tag, "_bvalid_hold"}, 32'(bus.S_AXI_bvalid), 32'h1);
        end
        bus.S_AXI_bready = 1'b1;
        tick();
        bus.S_AXI_bready = 1'b0;
        check_eq({tag, "_bvalid_clr"}, 32'(bus.S_AXI_bvalid), 32'h0);
    endtask

    task automatic pulse_start(input string tag);
        start = 1'b1;
        tick();
        check_stream({tag, "_arm"});
        start = 1'b0;
    endtask

    // Offer stim[] beats until the model reports the capture complete.
    task automatic send_beats(input string tag, input bit gaps);
        for (int i = 0; i < 400 && !m_done; i++) begin
            bus.y_tvalid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.y_tdata  = stim[m_count];
            tick();
            check_stream(tag);
        end
        bus.y_tvalid = 1'b0;
        check_eq({tag, "_complete"}, 32'(m_done), 32'h1);
    endtask

    task automatic read_all(input string tag, input int rdelay);
        logic [31:0] d;
        for (int i = 0; i < DEPTH; i++)
            axi_read($sformatf("%s_score%0d", tag, i), 32'(4 * i), rdelay, d);
        axi_read({tag, "_status"}, 32'h40, 0, d);
        axi_read({tag, "_argmax"}, 32'h44, 0, d);
        axi_read({tag, "_unmapped"}, 32'h48, 0, d);
    endtask

    initial begin
        logic [31:0] d;
        int tie_vals [DEPTH] = '{-5, 7, 3, 7, -1, 0, 0, 0, 0, 0};

        rst = 1'b1;
        start = 1'b0;
        bus.y_tdata = '0;   bus.y_tvalid = 1'b0;
        bus.S_AXI_awaddr = '0; bus.S_AXI_awprot = '0; bus.S_AXI_awvalid = 1'b0;
        bus.S_AXI_wdata = '0;  bus.S_AXI_wstrb = '0;  bus.S_AXI_wvalid = 1'b0;
        bus.S_AXI_bready = 1'b0;
        bus.S_AXI_araddr = '0; bus.S_AXI_arprot = '0; bus.S_AXI_arvalid = 1'b0;
        bus.S_AXI_rready = 1'b0;
        model_reset();

        // Reset held 30 cycles
        repeat (30) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        tick();
        axi_read("reset_status", 32'h40, 0, d);
        check_eq("reset_status_zero", d, 32'h0);

        // Full-rate capture of 100+i
        for (int i = 0; i < DEPTH; i++) stim[i] = 32'(100 + i);
        pulse_start("full");
        send_beats("full", 1'b0);
        read_all("full", 0);
        axi_read("full_status_lit", 32'h40, 0, d);
        check_eq("full_status_0a01", d, 32'h0A01);
        axi_read("full_argmax_lit", 32'h44, 0, d);
        check_eq("full_argmax_9", d, 32'd9);

        // Signed argmax with a tie
        for (int i = 0; i < DEPTH; i++) stim[i] = 32'(tie_vals[i]);
        pulse_start("tie");
        send_beats("tie", 1'b0);
        axi_read("tie_argmax", 32'h44, 0, d);
        check_eq("tie_argmax_1", d, 32'd1);
        axi_read("tie_neg_score", 32'h00, 0, d);
        check_eq("tie_neg_value", d, 32'hFFFF_FFFB);

        // start held 10 cycles, 12 beats offered
        for (int i = 0; i < 12; i++) stim[i] = $urandom;
        start = 1'b1;
        tick();
        check_stream("held_arm");
        for (int k = 0; k < 12; k++) begin
            start        = (k < 9);
            bus.y_tvalid = 1'b1;
            bus.y_tdata  = stim[k];
            tick();
            check_stream($sformatf("held_k%0d", k));
        end
        bus.y_tvalid = 1'b0;
        start = 1'b0;
        read_all("held", 0);

        // A start edge in the middle of a capture changes nothing
        for (int i = 0; i < 12; i++) stim[i] = $urandom;
        pulse_start("mid");
        for (int k = 0; k < 12; k++) begin
            start        = (k == 3);
            bus.y_tvalid = 1'b1;
            bus.y_tdata  = stim[k];
            tick();
            check_stream($sformatf("mid_k%0d", k));
        end
        bus.y_tvalid = 1'b0;
        start = 1'b0;
        axi_read("mid_status", 32'h40, 0, d);

        // Random data with random valid gaps and read backpressure
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < DEPTH; i++)
                stim[i] = (i > 0 && $urandom_range(0, 3) == 0) ? stim[$urandom_range(0, i - 1)] : $urandom;
            pulse_start($sformatf("rnd%0d", r));
            send_beats($sformatf("rnd%0d", r), 1'b1);
            read_all($sformatf("rnd%0d", r), (r == 0) ? 5 : 0);
        end

        // Writes: discarded address, then W1C with delayed bready
        axi_write("wr_other", 32'h44, 32'h1, 0);
        check_stream("wr_other_after");
        axi_write("w1c", 32'h40, 32'h1, 3);
        check_stream("w1c_after");
        axi_read("w1c_status", 32'h40, 0, d);
        check_eq("w1c_status_idle", d, 32'h0A00);

        // Reset aborts a capture after 4 beats
        for (int i = 0; i < DEPTH; i++) stim[i] = $urandom;
        pulse_start("abort");
        for (int k = 0; k < 4; k++) begin
            bus.y_tvalid = 1'b1;
            bus.y_tdata  = stim[k];
            tick();
            check_stream($sformatf("abort_k%0d", k));
        end
        bus.y_tvalid = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check_all_zero("abort_async");
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_stream("abort_released");
        read_all("abort", 0);
        for (int i = 0; i < DEPTH; i++) stim[i] = $urandom;
        pulse_start("after_abort");
        send_beats("after_abort", 1'b0);
        read_all("after_abort", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
